// File: rtl/gpioemu_bus_master_if.sv
// Signal bundle between the gpioemu bus master, its local request/response port,
// and the gpioemu register bus it drives.
interface gpioemu_bus_master_if;
    // Both local ports use valid/ready. A beat transfers on a rising edge where
    // valid && ready. Once valid is high, it and its payload stay stable until
    // that edge. Ready may be high or low independently of valid.
    logic        req_valid;
    logic        req_ready;
    logic [23:0] op_a;
    logic [23:0] op_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_product;
    logic [23:0] rsp_ones;
    logic        rsp_overflow;
    logic        rsp_timeout;
    logic [15:0] op_count;
    logic [15:0] saddress;
    logic        swr;
    logic        srd;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in;
    logic [3:0]  dbg_state;

    modport master (
        input  req_valid, op_a, op_b, rsp_ready, sdata_in,
        output req_ready, rsp_valid, rsp_product, rsp_ones, rsp_overflow,
               rsp_timeout, op_count, saddress, swr, srd, sdata_out, dbg_state
    );

    modport slave (
        output req_valid, op_a, op_b, rsp_ready, sdata_in,
        input  req_ready, rsp_valid, rsp_product, rsp_ones, rsp_overflow,
               rsp_timeout, op_count, saddress, swr, srd, sdata_out, dbg_state
    );
endinterface

// File: rtl/gpioemu_bus_master.sv
// Runs one complete gpioemu multiply per request: write both operands, start,
// poll status, read W and L, then return them as a single response beat.
module gpioemu_bus_master #(
    parameter int          STROBE_CYCLES = 2,
    parameter int          POLL_GAP      = 4,
    parameter int          MAX_POLLS     = 16,
    parameter logic [15:0] ADDR_A1       = 16'h037F,
    parameter logic [15:0] ADDR_A2       = 16'h0388,
    parameter logic [15:0] ADDR_CTRL     = 16'h03A0,
    parameter logic [15:0] ADDR_W        = 16'h0390,
    parameter logic [15:0] ADDR_L        = 16'h0398
) (
    input  logic                        clk,
    input  logic                        n_reset,
    gpioemu_bus_master_if.master        bus
);

    typedef enum logic [3:0] {
        IDLE, WR_A1, WR_A2, WR_GO, GAP, RD_STAT, RD_W, RD_L, RESP
    } state_t;

    // Phase 0 is SETUP, 1..STROBE_CYCLES is STROBE, STROBE_CYCLES+1 is HOLD.
    localparam int PW  = $clog2(STROBE_CYCLES + 2);
    localparam int GW  = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
    localparam int PLW = $clog2(MAX_POLLS + 1);
    localparam logic [PW-1:0]  PH_HOLD    = PW'(STROBE_CYCLES + 1);
    localparam logic [PW-1:0]  PH_LAST_ST = PW'(STROBE_CYCLES);
    localparam logic [GW-1:0]  GAP_LAST   = GW'(POLL_GAP - 1);
    localparam logic [PLW-1:0] POLL_LAST  = PLW'(MAX_POLLS - 1);

    state_t          state;
    logic [PW-1:0]   phase;
    logic [GW-1:0]   gap_cnt;
    logic [PLW-1:0]  poll_cnt;
    logic [23:0]     b_q;
    logic [31:0]     w_q;
    logic            ovf_q;
    logic            is_read;
    logic            in_access;

    assign is_read   = (state == RD_STAT) || (state == RD_W) || (state == RD_L);
    assign in_access = (state == WR_A1) || (state == WR_A2) || (state == WR_GO) || is_read;
    assign bus.dbg_state = state;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state            <= IDLE;
            phase            <= '0;
            gap_cnt          <= '0;
            poll_cnt         <= '0;
            b_q              <= '0;
            w_q              <= '0;
            ovf_q            <= 1'b0;
            bus.req_ready    <= 1'b1;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_product  <= '0;
            bus.rsp_ones     <= '0;
            bus.rsp_overflow <= 1'b0;
            bus.rsp_timeout  <= 1'b0;
            bus.op_count     <= '0;
            bus.saddress     <= '0;
            bus.swr          <= 1'b0;
            bus.srd          <= 1'b0;
            bus.sdata_out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        b_q           <= bus.op_b;
                        poll_cnt      <= '0;
                        phase         <= '0;
                        bus.req_ready <= 1'b0;
                        bus.saddress  <= ADDR_A1;
                        bus.sdata_out <= {8'h00, bus.op_a};
                        state         <= WR_A1;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        phase        <= '0;
                        bus.saddress <= ADDR_CTRL;
                        state        <= RD_STAT;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        if (!bus.rsp_timeout) bus.op_count <= bus.op_count + 16'd1;
                        state <= IDLE;
                    end
                end

                default: begin
                    if (!in_access) begin
                        state <= IDLE;
                    end else if (phase == '0) begin
                        phase <= phase + 1'b1;
                        if (is_read) bus.srd <= 1'b1;
                        else         bus.swr <= 1'b1;
                    end else if (phase != PH_HOLD) begin
                        if (phase == PH_LAST_ST) begin
                            bus.swr <= 1'b0;
                            bus.srd <= 1'b0;
                        end
                        phase <= phase + 1'b1;
                    end else begin
                        // End of HOLD: sample read data, then set up the next step.
                        phase         <= '0;
                        bus.saddress  <= '0;
                        bus.sdata_out <= '0;
                        case (state)
                            WR_A1: begin
                                bus.saddress  <= ADDR_A2;
                                bus.sdata_out <= {8'h00, b_q};
                                state         <= WR_A2;
                            end
                            WR_A2: begin
                                bus.saddress  <= ADDR_CTRL;
                                bus.sdata_out <= 32'h0000_0001;
                                state         <= WR_GO;
                            end
                            WR_GO: begin
                                gap_cnt <= '0;
                                state   <= GAP;
                            end
                            RD_STAT: begin
                                if (bus.sdata_in[1]) begin
                                    ovf_q        <= !bus.sdata_in[0];
                                    bus.saddress <= ADDR_W;
                                    state        <= RD_W;
                                end else if (poll_cnt == POLL_LAST) begin
                                    bus.rsp_product  <= '0;
                                    bus.rsp_ones     <= '0;
                                    bus.rsp_overflow <= 1'b0;
                                    bus.rsp_timeout  <= 1'b1;
                                    bus.rsp_valid    <= 1'b1;
                                    state            <= RESP;
                                end else begin
                                    poll_cnt <= poll_cnt + 1'b1;
                                    gap_cnt  <= '0;
                                    state    <= GAP;
                                end
                            end
                            RD_W: begin
                                w_q          <= bus.sdata_in;
                                bus.saddress <= ADDR_L;
                                state        <= RD_L;
                            end
                            RD_L: begin
                                bus.rsp_product  <= w_q;
                                bus.rsp_ones     <= bus.sdata_in[23:0];
                                bus.rsp_overflow <= ovf_q;
                                bus.rsp_timeout  <= 1'b0;
                                bus.rsp_valid    <= 1'b1;
                                state            <= RESP;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpioemu_bus_master.sv
// Bench for gpioemu_bus_master: a peripheral model answers reads, a monitor logs
// bus accesses, and each scenario task checks responses and the access log.
module tb_gpioemu_bus_master;

    localparam logic [15:0] A_A1   = 16'h037F;
    localparam logic [15:0] A_A2   = 16'h0388;
    localparam logic [15:0] A_CTRL = 16'h03A0;
    localparam logic [15:0] A_W    = 16'h0390;
    localparam logic [15:0] A_L    = 16'h0398;
    localparam int          GAP_CYCLES = 4;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    gpioemu_bus_master_if bus_if ();

    gpioemu_bus_master dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus_if)
    );

    // Access record: {srd, swr, saddress, sdata_out}
    logic [49:0] exp_q[$];
    logic [49:0] obs_q[$];
    int          gap_q[$];
    // Response record: {product, ones, overflow, timeout}
    logic [57:0] rsp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    int          busy_n;
    logic [1:0]  busy_stat;
    logic [1:0]  done_stat;
    logic [31:0] w_val;
    logic [23:0] l_val;

    int   ctrl_reads = 0;
    int   idle_run   = 0;
    int   last_idle  = 0;
    logic srd_prev   = 1'b0;
    logic swr_prev   = 1'b0;

    // Peripheral model and bus monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!n_reset) bus_if.sdata_in = 32'h0;
        if (bus_if.req_ready) ctrl_reads = 0;
        if ((bus_if.srd && !srd_prev) || (bus_if.swr && !swr_prev)) begin
            obs_q.push_back({bus_if.srd, bus_if.swr, bus_if.saddress, bus_if.sdata_out});
            if (bus_if.srd && bus_if.saddress == A_CTRL) begin
                ctrl_reads++;
                gap_q.push_back(last_idle);
                bus_if.sdata_in = (ctrl_reads > busy_n) ? {30'h0, done_stat} : {30'h0, busy_stat};
            end else if (bus_if.srd && bus_if.saddress == A_W) begin
                bus_if.sdata_in = w_val;
            end else if (bus_if.srd && bus_if.saddress == A_L) begin
                bus_if.sdata_in = {8'h5A, l_val};
            end
        end
        if (bus_if.saddress == 16'h0 && !bus_if.swr && !bus_if.srd) begin
            idle_run++;
        end else if (idle_run != 0) begin
            last_idle = idle_run;
            idle_run  = 0;
        end
        srd_prev = bus_if.srd;
        swr_prev = bus_if.swr;
    end

    task automatic set_model(input int bn, input logic [1:0] bs, input logic [1:0] ds,
                             input logic [31:0] w, input logic [23:0] l);
        busy_n = bn; busy_stat = bs; done_stat = ds; w_val = w; l_val = l;
    endtask

    task automatic push_bus(input logic [23:0] a, input logic [23:0] b,
                            input int n_stat, input bit rd_data);
        exp_q.push_back({1'b0, 1'b1, A_A1, {8'h00, a}});
        exp_q.push_back({1'b0, 1'b1, A_A2, {8'h00, b}});
        exp_q.push_back({1'b0, 1'b1, A_CTRL, 32'h1});
        for (int i = 0; i < n_stat; i++) exp_q.push_back({1'b1, 1'b0, A_CTRL, 32'h0});
        if (rd_data) begin
            exp_q.push_back({1'b1, 1'b0, A_W, 32'h0});
            exp_q.push_back({1'b1, 1'b0, A_L, 32'h0});
        end
    endtask

    task automatic issue(input logic [23:0] a, input logic [23:0] b, input bit keep);
        @(negedge clk);
        bus_if.op_a = a;
        bus_if.op_b = b;
        bus_if.req_valid = 1'b1;
        n_cmp++;
        if (bus_if.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL req_ready_before_accept: got %b want 1", bus_if.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        if (!keep) bus_if.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (bus_if.rsp_valid !== 1'b1 && lat < 400) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (bus_if.rsp_valid !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_wait: rsp_valid still %b after %0d cycles", bus_if.rsp_valid, lat);
        end
    endtask

    task automatic check_latency(input string name, input int lat, input int want);
        n_cmp++;
        if (lat !== want) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, want);
        end
    endtask

    task automatic check_rsp(input string name);
        logic [57:0] exp;
        logic [57:0] got;
        exp = rsp_q.pop_front();
        got = {bus_if.rsp_product, bus_if.rsp_ones, bus_if.rsp_overflow, bus_if.rsp_timeout};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s_rsp: got prod=%h ones=%h ovf=%b to=%b want prod=%h ones=%h ovf=%b to=%b",
                     name, got[57:26], got[25:2], got[1], got[0], exp[57:26], exp[25:2], exp[1], exp[0]);
        end
        bus_if.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.rsp_ready = 1'b0;
        n_cmp++;
        if (bus_if.rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_rsp_drop: rsp_valid got %b want 0", name, bus_if.rsp_valid);
        end
    endtask

    task automatic check_count(input string name, input logic [15:0] want);
        n_cmp++;
        if (bus_if.op_count !== want) begin
            n_bad++;
            $display("FAIL %s_op_count: got %0d want %0d", name, bus_if.op_count, want);
        end
    endtask

    task automatic compare_bus(input string name);
        logic [49:0] got;
        logic [49:0] exp;
        int          g;
        while (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL %s_bus_missing: no access seen, want rd=%b wr=%b addr=%h data=%h",
                         name, exp[49], exp[48], exp[47:32], exp[31:0]);
            end else begin
                got = obs_q.pop_front();
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL %s_bus_access: got rd=%b wr=%b addr=%h data=%h want rd=%b wr=%b addr=%h data=%h",
                             name, got[49], got[48], got[47:32], got[31:0],
                             exp[49], exp[48], exp[47:32], exp[31:0]);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_bus_extra: %0d unexpected accesses, want 0", name, obs_q.size());
            obs_q.delete();
        end
        while (gap_q.size() != 0) begin
            g = gap_q.pop_front();
            n_cmp++;
            if (g != GAP_CYCLES) begin
                n_bad++;
                $display("FAIL %s_stat_gap: got %0d idle cycles want %0d", name, g, GAP_CYCLES);
            end
        end
    endtask

    task automatic test_reset();
        bus_if.req_valid = 1'b0;
        bus_if.rsp_ready = 1'b0;
        bus_if.op_a = '0;
        bus_if.op_b = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus_if.req_ready, bus_if.rsp_valid, bus_if.swr, bus_if.srd} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got rdy/vld/swr/srd=%b want 1000",
                     {bus_if.req_ready, bus_if.rsp_valid, bus_if.swr, bus_if.srd});
        end
        n_cmp++;
        if ({bus_if.saddress, bus_if.sdata_out} !== 48'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got addr=%h data=%h want 0", bus_if.saddress, bus_if.sdata_out);
        end
        n_cmp++;
        if ({bus_if.rsp_product, bus_if.rsp_ones, bus_if.rsp_overflow, bus_if.rsp_timeout} !== 58'h0) begin
            n_bad++;
            $display("FAIL reset_rsp: got prod=%h ones=%h want 0", bus_if.rsp_product, bus_if.rsp_ones);
        end
        n_cmp++;
        if (bus_if.dbg_state !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %0d want 0", bus_if.dbg_state);
        end
        check_count("reset", 16'd0);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        set_model(0, 2'b01, 2'b11, 32'd15, 24'd4);
        push_bus(24'd3, 24'd5, 1, 1'b1);
        rsp_q.push_back({32'd15, 24'd4, 1'b0, 1'b0});
        issue(24'd3, 24'd5, 1'b0);
        wait_rsp(lat);
        check_latency("basic", lat, 28);
        check_rsp("basic");
        check_count("basic", 16'd1);
        compare_bus("basic");
    endtask

    task automatic test_overflow();
        int lat;
        set_model(0, 2'b01, 2'b10, 32'hFE00_0001, 24'd8);
        push_bus(24'hFFFFFF, 24'hFFFFFF, 1, 1'b1);
        rsp_q.push_back({32'hFE00_0001, 24'd8, 1'b1, 1'b0});
        issue(24'hFFFFFF, 24'hFFFFFF, 1'b0);
        wait_rsp(lat);
        check_latency("overflow", lat, 28);
        check_rsp("overflow");
        check_count("overflow", 16'd2);
        compare_bus("overflow");
    endtask

    task automatic test_busy_polls();
        int lat;
        set_model(3, 2'b01, 2'b11, 32'h1234_5678, 24'h00000D);
        push_bus(24'h00ABCD, 24'h001234, 4, 1'b1);
        rsp_q.push_back({32'h1234_5678, 24'h00000D, 1'b0, 1'b0});
        issue(24'h00ABCD, 24'h001234, 1'b0);
        wait_rsp(lat);
        check_latency("busy", lat, 52);
        check_rsp("busy");
        check_count("busy", 16'd3);
        compare_bus("busy");
    endtask

    task automatic test_timeout();
        int lat;
        set_model(1000, 2'b01, 2'b11, 32'hDEAD_BEEF, 24'h777777);
        push_bus(24'd7, 24'd9, 16, 1'b0);
        rsp_q.push_back({32'h0, 24'h0, 1'b0, 1'b1});
        issue(24'd7, 24'd9, 1'b0);
        wait_rsp(lat);
        check_latency("timeout", lat, 20 + 15 * 8);
        check_rsp("timeout");
        check_count("timeout", 16'd3);
        compare_bus("timeout");
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [57:0] exp;
        set_model(0, 2'b01, 2'b11, 32'h0000_0200, 24'd2);
        push_bus(24'h000010, 24'h000020, 1, 1'b1);
        push_bus(24'h000007, 24'h000009, 1, 1'b1);
        rsp_q.push_back({32'h0000_0200, 24'd2, 1'b0, 1'b0});
        rsp_q.push_back({32'h0000_0200, 24'd2, 1'b0, 1'b0});
        issue(24'h000010, 24'h000020, 1'b1);
        bus_if.op_a = 24'h000007;
        bus_if.op_b = 24'h000009;
        wait_rsp(lat);
        exp = rsp_q[0];
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if ({bus_if.rsp_valid, bus_if.rsp_product, bus_if.rsp_ones, bus_if.rsp_overflow, bus_if.rsp_timeout}
                !== {1'b1, exp}) begin
                n_bad++;
                $display("FAIL hold_rsp: cycle %0d got vld=%b prod=%h ones=%h want vld=1 prod=%h ones=%h",
                         i, bus_if.rsp_valid, bus_if.rsp_product, bus_if.rsp_ones, exp[57:26], exp[25:2]);
            end
            n_cmp++;
            if (bus_if.req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_req_ready: cycle %0d got %b want 0", i, bus_if.req_ready);
            end
            n_cmp++;
            if ({bus_if.swr, bus_if.srd, bus_if.saddress} !== 18'h0) begin
                n_bad++;
                $display("FAIL hold_bus_idle: cycle %0d got swr=%b srd=%b addr=%h want 0",
                         i, bus_if.swr, bus_if.srd, bus_if.saddress);
            end
            @(negedge clk);
        end
        check_rsp("b2b_first");
        n_cmp++;
        if (bus_if.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_req_ready_rise: got %b want 1", bus_if.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        n_cmp++;
        if (bus_if.req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_second_accept: req_ready got %b want 0", bus_if.req_ready);
        end
        wait_rsp(lat);
        check_latency("b2b_second", lat, 28);
        check_rsp("b2b_second");
        check_count("b2b", 16'd5);
        compare_bus("b2b");
    endtask

    task automatic test_reset_mid_access();
        int lat;
        set_model(0, 2'b01, 2'b11, 32'd6, 24'd2);
        exp_q.push_back({1'b0, 1'b1, A_A1, 32'h0000_0002});
        exp_q.push_back({1'b0, 1'b1, A_A2, 32'h0000_0003});
        issue(24'd2, 24'd3, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus_if.swr, bus_if.saddress} !== {1'b1, A_A2}) begin
            n_bad++;
            $display("FAIL rst_pre_strobe: got swr=%b addr=%h want swr=1 addr=%h",
                     bus_if.swr, bus_if.saddress, A_A2);
        end
        #2;
        n_reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus_if.swr, bus_if.saddress, bus_if.rsp_valid, bus_if.req_ready} !== {1'b0, 16'h0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL rst_async: got swr=%b addr=%h vld=%b rdy=%b want swr=0 addr=0 vld=0 rdy=1",
                     bus_if.swr, bus_if.saddress, bus_if.rsp_valid, bus_if.req_ready);
        end
        check_count("rst_async", 16'd0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        compare_bus("rst_abort");
        push_bus(24'd2, 24'd3, 1, 1'b1);
        rsp_q.push_back({32'd6, 24'd2, 1'b0, 1'b0});
        issue(24'd2, 24'd3, 1'b0);
        wait_rsp(lat);
        check_latency("rst_fresh", lat, 28);
        check_rsp("rst_fresh");
        check_count("rst_fresh", 16'd1);
        compare_bus("rst_fresh");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_busy_polls();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
